// File: rtl/slide_window_seq.sv
// -----------------------------------------------------------------------------
// slide_window_seq
//
// Window-address sequencer for a sliding-text display. It owns the scrolling
// window start index and the digit-scan counter, each driven by its own
// programmable prescaler, and forms the message-ROM character address for
// the digit currently being scanned.
//
// Ports:
//   clk        in   1   system clock, all state updates on rising edge
//   rst        in   1   synchronous active-high reset
//   run        in   1   level, enables scrolling
//   dir        in   1   0 = left (index increments), 1 = right (decrements)
//   oneshot    in   1   1 = stop (DONE) after the step that wraps
//   load       in   1   one-cycle window load strobe
//   load_idx   in   AW  window index to load (out-of-range loads 0)
//   win_idx    out  AW  current window start index (registered)
//   scan_sel   out  SW  current digit select (registered)
//   char_addr  out  AW  character address for the selected digit
//   scan_tick  out  1   one-cycle pulse on each scan step (registered)
//   wrap       out  1   one-cycle pulse after a wrapping scroll step
//   busy       out  1   high while the scroll FSM is in RUN
// -----------------------------------------------------------------------------
module slide_window_seq #(
  parameter int MSG_LEN    = 12,
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int SHIFT_DIV  = 25000000,
  localparam int AW        = $clog2(MSG_LEN),
  localparam int SW        = $clog2(NUM_DIGITS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          dir,
  input  logic          oneshot,
  input  logic          load,
  input  logic [AW-1:0] load_idx,
  output logic [AW-1:0] win_idx,
  output logic [SW-1:0] scan_sel,
  output logic [AW-1:0] char_addr,
  output logic          scan_tick,
  output logic          wrap,
  output logic          busy
);

  localparam int SCW = $clog2(SCAN_DIV);
  localparam int SHW = $clog2(SHIFT_DIV);

  localparam logic [SCW-1:0] SCAN_LAST  = SCW'(SCAN_DIV - 1);
  localparam logic [SHW-1:0] SHIFT_LAST = SHW'(SHIFT_DIV - 1);
  localparam logic [SW-1:0]  SEL_LAST   = SW'(NUM_DIGITS - 1);
  localparam logic [AW-1:0]  WIN_LAST   = AW'(MSG_LEN - 1);
  localparam logic [AW:0]    MSG_W      = (AW+1)'(MSG_LEN);
  localparam logic [AW:0]    ND_LAST_W  = (AW+1)'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [SCW-1:0] scan_cnt_q, scan_cnt_d;
  logic [SW-1:0]  scan_sel_q, scan_sel_d;
  logic           scan_tick_q, scan_tick_d;
  logic [SHW-1:0] shift_cnt_q, shift_cnt_d;
  logic [AW-1:0]  win_q, win_d;
  logic           wrap_q, wrap_d;

  logic           step_s;
  logic           wraps_s;
  logic [AW-1:0]  win_next_s;
  logic [AW:0]    sum_s;

  // Free-running scan prescaler and digit select, independent of the FSM.
  always_comb begin
    scan_cnt_d  = scan_cnt_q + 1'b1;
    scan_sel_d  = scan_sel_q;
    scan_tick_d = 1'b0;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d  = '0;
      scan_tick_d = 1'b1;
      if (scan_sel_q == SEL_LAST) begin
        scan_sel_d = '0;
      end else begin
        scan_sel_d = scan_sel_q + 1'b1;
      end
    end else begin
      scan_sel_d = scan_sel_q;
    end
  end

  // Candidate next window index for a scroll step and whether it wraps.
  always_comb begin
    wraps_s    = 1'b0;
    win_next_s = win_q;
    if (dir) begin
      wraps_s    = (win_q == '0);
      win_next_s = wraps_s ? WIN_LAST : (win_q - 1'b1);
    end else begin
      wraps_s    = (win_q == WIN_LAST);
      win_next_s = wraps_s ? '0 : (win_q + 1'b1);
    end
  end

  // Scroll FSM next-state, shift prescaler and window index update.
  always_comb begin
    state_d     = state_q;
    shift_cnt_d = '0;
    win_d       = win_q;
    wrap_d      = 1'b0;
    // A load in the same cycle suppresses the scroll step entirely.
    step_s      = (state_q == S_RUN) && (shift_cnt_q == SHIFT_LAST) && !load;

    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (shift_cnt_q == SHIFT_LAST) begin
          shift_cnt_d = '0;
        end else begin
          shift_cnt_d = shift_cnt_q + 1'b1;
        end
        // A wrapping one-shot step wins over run falling in the same cycle.
        if (step_s && wraps_s && oneshot) begin
          state_d = S_DONE;
        end else if (!run) begin
          state_d     = S_IDLE;
          shift_cnt_d = '0;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (!run) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (load) begin
      win_d       = ({1'b0, load_idx} < MSG_W) ? load_idx : '0;
      shift_cnt_d = '0;
    end else if (step_s) begin
      win_d  = win_next_s;
      wrap_d = wraps_s;
    end else begin
      win_d = win_q;
    end
  end

  // Character address: window start plus digit offset, reduced modulo MSG_LEN.
  // Digit 0 is the rightmost, so it shows the last character of the window.
  always_comb begin
    sum_s     = {1'b0, win_q} + (ND_LAST_W - {{(AW+1-SW){1'b0}}, scan_sel_q});
    char_addr = '0;
    if (sum_s >= MSG_W) begin
      char_addr = AW'(sum_s - MSG_W);
    end else begin
      char_addr = AW'(sum_s);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      scan_cnt_q  <= '0;
      scan_sel_q  <= '0;
      scan_tick_q <= 1'b0;
      shift_cnt_q <= '0;
      win_q       <= '0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      scan_cnt_q  <= scan_cnt_d;
      scan_sel_q  <= scan_sel_d;
      scan_tick_q <= scan_tick_d;
      shift_cnt_q <= shift_cnt_d;
      win_q       <= win_d;
      wrap_q      <= wrap_d;
    end
  end

  assign win_idx   = win_q;
  assign scan_sel  = scan_sel_q;
  assign scan_tick = scan_tick_q;
  assign wrap      = wrap_q;
  assign busy      = (state_q == S_RUN);

endmodule
